// File: rtl/rca_resp_checker.sv
// rca_resp_checker
//   Response monitor for a ripple-carry adder. Each accepted vector carries the
//   operands applied to the adder plus the adder's observed result. The
//   checker recomputes a+b+cin, tallies matches and mismatches over NUM_VEC
//   vectors, captures the first failing vector, and reports a pass verdict.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     begin a run (honoured in IDLE or DONE only)
//   in_valid  vector on a/b/cin/s/carry is valid
//   in_ready  checker accepts a vector this cycle
//   a, b      operands applied to the adder
//   cin       carry-in applied to the adder
//   s         observed adder sum
//   carry     observed adder carry-out
//   busy      run in progress
//   done      run complete, held until the next start
//   pass      done and no mismatches seen
//   pass_cnt  matching vectors this run
//   fail_cnt  mismatching vectors this run
//   err_vec   first failing vector as {a,b,cin,carry,s}
//   err_exp   expected {carry,s} for err_vec
//
// state | meaning
// IDLE  | waiting for start, inputs ignored
// RUN   | accepting and checking vectors, one per cycle
// DONE  | verdict valid, counters held until the next start
module rca_resp_checker #(
  parameter  int WIDTH   = 4,
  parameter  int NUM_VEC = 10,
  localparam int CW      = $clog2(NUM_VEC + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  input  logic [WIDTH-1:0]   s,
  input  logic               carry,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CW-1:0]      pass_cnt,
  output logic [CW-1:0]      fail_cnt,
  output logic [3*WIDTH+1:0] err_vec,
  output logic [WIDTH:0]     err_exp
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_VEC = CW'(NUM_VEC - 1);

  state_t        state;
  logic [CW-1:0] vec_cnt;
  logic [WIDTH:0] exp_sum;
  logic           match;

  // Zero-extended sum so the top bit is the expected carry-out.
  assign exp_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign match   = (exp_sum == {carry, s});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      vec_cnt  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_vec  <= '0;
      err_exp  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // A vector presented alongside start is not counted: in_ready is
          // still low on this edge.
          if (start) begin
            state    <= ST_RUN;
            vec_cnt  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            err_vec  <= '0;
            err_exp  <= '0;
          end
        end
        ST_RUN: begin
          // in_ready is high throughout RUN, so in_valid alone accepts.
          if (in_valid) begin
            vec_cnt <= vec_cnt + CW'(1);
            if (match) begin
              pass_cnt <= pass_cnt + CW'(1);
            end else begin
              fail_cnt <= fail_cnt + CW'(1);
              if (fail_cnt == '0) begin
                err_vec <= {a, b, cin, carry, s};
                err_exp <= exp_sum;
              end
            end
            if (vec_cnt == LAST_VEC) begin
              state    <= ST_DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              // Fold in the final vector's outcome, which fail_cnt does not
              // reflect until after this edge.
              pass     <= match && (fail_cnt == '0);
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          pass     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_resp_checker.sv
module tb_rca_resp_checker;

  localparam int WIDTH   = 4;
  localparam int NUM_VEC = 10;
  localparam int CW      = $clog2(NUM_VEC + 1);

  logic               clk;
  logic               rst;
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               cin;
  logic [WIDTH-1:0]   s;
  logic               carry;
  logic               busy;
  logic               done;
  logic               pass;
  logic [CW-1:0]      pass_cnt;
  logic [CW-1:0]      fail_cnt;
  logic [3*WIDTH+1:0] err_vec;
  logic [WIDTH:0]     err_exp;

  rca_resp_checker #(.WIDTH(WIDTH), .NUM_VEC(NUM_VEC)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .s        (s),
    .carry    (carry),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt),
    .err_vec  (err_vec),
    .err_exp  (err_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       carry;
  } vec_t;

  typedef struct packed {
    logic          pass;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic [13:0]   err_vec;
    logic [4:0]    err_exp;
  } res_t;

  res_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   acc_cnt = 0;
  int   done_seen = 0;
  logic done_q = 1'b0;

  vec_t good_v[10];
  vec_t bad_v[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    a = v.a; b = v.b; cin = v.cin; s = v.s; carry = v.carry;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    if (!done) chk({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  // Accepts as seen on the pins, cleared whenever a run legitimately starts.
  always @(posedge clk) begin
    if (rst) acc_cnt <= 0;
    else if (start && !busy) acc_cnt <= 0;
    else if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  // Monitor: on each rising edge of done, pop the expected verdict and compare.
  always @(negedge clk) begin
    if (done && !done_q) begin
      done_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("run_pass",     32'(pass),     32'(e.pass));
        chk("run_pass_cnt", 32'(pass_cnt), 32'(e.pass_cnt));
        chk("run_fail_cnt", 32'(fail_cnt), 32'(e.fail_cnt));
        chk("run_err_vec",  32'(err_vec),  32'(e.err_vec));
        chk("run_err_exp",  32'(err_exp),  32'(e.err_exp));
        chk("run_accepts",  32'(acc_cnt),  32'(NUM_VEC));
        chk("run_busy_low", 32'({busy, in_ready}), 32'd0);
      end
    end
    done_q = done;
  end

  initial begin
    // a, b, cin, s, carry -- hand computed.
    good_v[0] = '{4'd3,  4'd4,  1'b0, 4'd7,  1'b0};
    good_v[1] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
    good_v[2] = '{4'd1,  4'd1,  1'b0, 4'd2,  1'b0};
    good_v[3] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1};
    good_v[4] = '{4'd7,  4'd8,  1'b1, 4'd0,  1'b1};
    good_v[5] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
    good_v[6] = '{4'd10, 4'd5,  1'b0, 4'd15, 1'b0};
    good_v[7] = '{4'd9,  4'd9,  1'b1, 4'd3,  1'b1};
    good_v[8] = '{4'd2,  4'd13, 1'b1, 4'd0,  1'b1};
    good_v[9] = '{4'd6,  4'd3,  1'b1, 4'd10, 1'b0};
    for (int i = 0; i < 10; i++) bad_v[i] = good_v[i];
    bad_v[2] = '{4'd5,  4'd9, 1'b1, 4'd14, 1'b0};
    bad_v[6] = '{4'd10, 4'd5, 1'b0, 4'd14, 1'b0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; s = '0; carry = 1'b0;
    tick(); tick();
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cnts",     32'({pass_cnt, fail_cnt}), 32'd0);
    rst = 1'b0;
    tick();

    // Vectors presented in IDLE are ignored.
    send(good_v[0]);
    send(bad_v[2]);
    chk("idle_ignored", 32'({busy, pass_cnt, fail_cnt}), 32'd0);

    // Run A: start with a (bad) vector alongside it, which must not count;
    // start pulsed mid-run is ignored.
    sb.push_back('{1'b1, CW'(10), CW'(0), 14'd0, 5'd0});
    a = 4'd1; b = 4'd1; cin = 1'b0; s = 4'd15; carry = 1'b1;
    start = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("a_start_state", 32'({busy, in_ready, done}), 32'b110);
    chk("a_start_cnts",  32'({pass_cnt, fail_cnt}), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) start = 1'b1;
      send(good_v[i]);
      start = 1'b0;
      if (i == 5) chk("a_midstart_cnt", 32'(pass_cnt), 32'd6);
    end
    wait_done("a");
    send(bad_v[2]);
    send(bad_v[6]);
    chk("a_after_done", 32'({done, pass_cnt, fail_cnt}), 32'({1'b1, CW'(10), CW'(0)}));

    // Run B: start from DONE, in_valid every other cycle, two corruptions.
    sb.push_back('{1'b0, CW'(8), CW'(2), {4'd5, 4'd9, 1'b1, 1'b0, 4'd14}, 5'b01111});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b_start_clear", 32'({done, busy, pass_cnt, fail_cnt}), 32'({1'b0, 1'b1, CW'(0), CW'(0)}));
    for (int i = 0; i < 10; i++) begin
      send(bad_v[i]);
      if (i == 2) chk("b_first_err", 32'({fail_cnt, err_exp}), 32'({CW'(1), 5'b01111}));
      if (i < 9) begin
        chk("b_not_done_early", 32'(done), 32'd0);
        tick();
      end
    end
    wait_done("b");

    // Run C: reset after 4 accepts, then a clean run.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) send(good_v[i]);
    chk("c_mid_cnt", 32'(pass_cnt), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("c_rst_flags", 32'({busy, in_ready, done, pass}), 32'd0);
    chk("c_rst_cnts",  32'({pass_cnt, fail_cnt}), 32'd0);
    chk("c_rst_err",   32'({err_vec, err_exp}), 32'd0);
    #2 rst = 1'b0;
    tick();
    sb.push_back('{1'b1, CW'(10), CW'(0), 14'd0, 5'd0});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) send(good_v[9 - i]);
    wait_done("c");

    tick(); tick();
    chk("sb_empty",   32'(sb.size()), 32'd0);
    chk("done_count", 32'(done_seen), 32'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
